julia_scheduler: RTL

Frame-level scheduler for the Julia worker array. It walks the pixel raster, hands one (x, y) job at a time to a free worker, and arbitrates round-robin among finished workers. Each result goes out as an address/pixel beat on a valid/ready write port, and the worker is acknowledged so it can be reused. It sits between the frame-start control and the worker array on one side, and the frame-buffer write path on the other.

---
 rtl/julia_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/julia_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/julia_pkg.sv
// Shared types and sizing helpers for the Julia frame scheduler.
package julia_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;
  localparam int unsigned NUM_PIX    = DEF_WIDTH * DEF_HEIGHT;
  localparam int unsigned IDX_W      = $clog2(NUM_PIX);

  // Width needed to index n items, never less than one bit.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the pointer upward, pointer moves
// past the winner whenever a grant is taken.
module rr_arbiter
  import julia_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = bits_for(N);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/julia_scheduler.sv
// Frame scheduler: walks the raster handing jobs to free workers and funnels
// finished results, round-robin, into a registered valid/ready write port.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | dispatching jobs and collecting results
// DRAIN | all jobs issued, collecting remaining results
module julia_scheduler
  import julia_pkg::*;
#(
  parameter int          NUM_JULIA = 8,
  parameter int          WIDTH     = 640,
  parameter int          HEIGHT    = 480,
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   frame_done,
  output logic [NUM_JULIA-1:0]   job_valid,
  output logic [X_W-1:0]         job_x,
  output logic [Y_W-1:0]         job_y,
  input  logic [NUM_JULIA-1:0]   worker_done,
  input  logic [NUM_JULIA*8-1:0] worker_pixel,
  output logic [NUM_JULIA-1:0]   worker_ack,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [31:0]            wr_addr,
  output logic [7:0]             wr_data
);

  localparam int PIX_N = WIDTH * HEIGHT;
  localparam int TAG_W = bits_for(PIX_N);
  localparam int CNT_W = bits_for(PIX_N + 1);

  sched_state_t state, state_nxt;

  logic [X_W-1:0]   x_cnt;
  logic [Y_W-1:0]   y_cnt;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] written;
  logic [NUM_JULIA-1:0] wk_busy;
  logic [TAG_W-1:0] tag [NUM_JULIA];

  logic [NUM_JULIA-1:0] free_sel;
  logic                 free_any;
  logic [NUM_JULIA-1:0] cand;
  logic [NUM_JULIA-1:0] gnt;
  logic [TAG_W-1:0]     sel_tag;
  logic [7:0]           sel_pix;
  logic load_ok, grant_fire, hs, last_hs;
  logic accept_start, dispatch;

  assign cand       = (state != IDLE) ? (worker_done & wk_busy) : '0;
  assign load_ok    = !wr_valid || wr_ready;
  assign grant_fire = load_ok && (|cand);
  assign hs         = wr_valid && wr_ready;
  assign last_hs    = hs && (written == CNT_W'(PIX_N - 1));

  rr_arbiter #(.N(NUM_JULIA)) u_arb (
    .clk   (clk),
    .n_rst (n_rst),
    .req   (cand),
    .en    (load_ok),
    .gnt   (gnt)
  );

  // Lowest-index free worker gets the next job.
  always_comb begin
    free_sel = '0;
    free_any = 1'b0;
    for (int k = 0; k < NUM_JULIA; k++) begin
      if (!free_any && !wk_busy[k]) begin
        free_any    = 1'b1;
        free_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_tag = '0;
    sel_pix = '0;
    for (int k = 0; k < NUM_JULIA; k++) begin
      if (gnt[k]) begin
        sel_tag = sel_tag | tag[k];
        sel_pix = sel_pix | worker_pixel[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    dispatch     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = RUN;
          accept_start = 1'b1;
        end
      end
      RUN: begin
        if (issued == CNT_W'(PIX_N)) state_nxt = DRAIN;
        else                         dispatch  = free_any;
      end
      DRAIN: begin
        if (last_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      job_valid  <= '0;
      job_x      <= '0;
      job_y      <= '0;
      worker_ack <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      issued     <= '0;
      written    <= '0;
      wk_busy    <= '0;
      for (int k = 0; k < NUM_JULIA; k++) tag[k] <= '0;
    end else begin
      job_valid  <= '0;
      worker_ack <= '0;
      frame_done <= (state == DRAIN) && last_hs;

      if (accept_start) begin
        busy    <= 1'b1;
        x_cnt   <= '0;
        y_cnt   <= '0;
        issued  <= '0;
        written <= '0;
      end
      if ((state == DRAIN) && last_hs) busy <= 1'b0;

      if (dispatch) begin
        job_valid <= free_sel;
        job_x     <= x_cnt;
        job_y     <= y_cnt;
        issued    <= issued + CNT_W'(1);
        if (x_cnt == X_W'(WIDTH - 1)) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + Y_W'(1);
        end else begin
          x_cnt <= x_cnt + X_W'(1);
        end
      end

      // Dispatch only targets free workers and collection only busy ones.
      for (int k = 0; k < NUM_JULIA; k++) begin
        if (dispatch && free_sel[k]) begin
          tag[k]     <= TAG_W'(issued);
          wk_busy[k] <= 1'b1;
        end else if (grant_fire && gnt[k]) begin
          wk_busy[k] <= 1'b0;
        end
      end

      if (hs) written <= written + CNT_W'(1);

      if (grant_fire) begin
        wr_valid   <= 1'b1;
        wr_addr    <= BASE_ADDR + 32'(sel_tag);
        wr_data    <= sel_pix;
        worker_ack <= gnt;
      end else if (hs) begin
        wr_valid <= 1'b0;
      end
    end
  end

endmodule
